minmax_tracker: RTL
===================

MINMAX_TRACKER -- requirements
Module: minmax_tracker

Interface
REQ-001 Parameter WIDTH, default 64, SHALL set the data operand width in bits; legal values are even and at least 4.
REQ-002 Parameter IDXW, default 16, SHALL set the width of the beat counter and the index outputs.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  SHALL be the asynchronous, active-low reset; it asserts asynchronously and its release is synchronous to clk.
REQ-005 Start  in  1  SHALL request a new frame; it is honoured only in IDLE.
REQ-006 Signed  in  1  SHALL select the comparison mode (1 = two's complement, 0 = unsigned); it is sampled only with an honoured Start.
REQ-007 InValid / InReady  in / out  1 / 1  SHALL form the input beat handshake; a beat transfers when both are 1.
REQ-008 InData  in  WIDTH  SHALL carry the beat value.
REQ-009 InLast  in  1  SHALL mark the final beat of a frame.
REQ-010 OutValid / OutReady  out / in  1 / 1  SHALL form the result handshake.
REQ-011 Min, Max  out  WIDTH  SHALL be the frame extremes under the latched mode.
REQ-012 MinIdx, MaxIdx  out  IDXW  SHALL be the zero-based beat indices of Min and Max.
REQ-013 Count  out  IDXW  SHALL be the number of beats accepted in the frame, saturating.
REQ-014 Sat  out  1  SHALL flag that Count saturated during the frame.

Function
REQ-015 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-016 Transitions: IDLE->ACCUM on Start; ACCUM->DONE on an accepted beat with InLast=1; DONE->IDLE when OutValid and OutReady are both 1.
REQ-017 On entry to ACCUM, Count, Sat and both indices SHALL clear and Signed SHALL be latched into a mode register.
REQ-018 InReady SHALL be 1 only in ACCUM; OutValid SHALL be 1 only in DONE.
REQ-019 Start in ACCUM or DONE SHALL be ignored; Start and InValid together in IDLE SHALL transfer no beat.
REQ-020 The first accepted beat SHALL load Min=Max=InData and MinIdx=MaxIdx=0 unconditionally.
REQ-021 Each later beat SHALL replace Min only if InData < Min, and Max only if InData > Max, under the latched mode; the index is the current Count value.
REQ-022 On ties (equal values), the stored value and its earliest index SHALL be kept.
REQ-023 In signed mode, ordering SHALL be decided by inverting the MSB of both operands and then comparing them as unsigned values.
REQ-024 The comparison SHALL be combinational from InData against the registered Min and Max, with results registered on the same edge: a single-cycle update and a sustained throughput of one beat per clock.
REQ-025 Count SHALL increment per accepted beat; at 2^IDXW-1 it SHALL hold and set Sat, and later beats are still compared with their index held at 2^IDXW-1.
REQ-026 A single-beat frame (InLast on the first beat) SHALL give Min=Max=InData, indices 0, Count=1.
REQ-027 Min, Max, MinIdx, MaxIdx, Count and Sat SHALL be stable while OutValid=1 and OutReady=0, and SHALL hold their values in IDLE until the next honoured Start.
REQ-028 When the DONE->IDLE transition and a Start coincide, the Start SHALL be ignored; Start is honoured from the following cycle.

Reset
REQ-029 While reset_n=0, the FSM SHALL be in IDLE, and InReady, OutValid, Sat, the mode register, Count, Min, Max, MinIdx and MaxIdx SHALL all be 0.
REQ-030 A reset in the middle of a frame SHALL discard that frame with no OutValid pulse; after release the block waits in IDLE for Start.

Verification
REQ-031 Unsigned frame, WIDTH=64, Signed=0, beats 5, 0xFFFF_FFFF_FFFF_FFFF, 3 (last) -> Min=3 at idx 2, Max=0xFFFF...F at idx 1, Count=3.
REQ-032 Same beats with Signed=1 -> Min=0xFFFF...F (-1) at idx 1, Max=5 at idx 0, Count=3.
REQ-033 Ties, Signed=0, beats 7, 7, 2, 2 (last) -> MinIdx=2, MaxIdx=0.
REQ-034 Back-pressure: OutReady held 0 for 10 cycles in DONE -> OutValid and all outputs stable, InReady=0, Start ignored; OutReady=1 -> IDLE next cycle.
REQ-035 Saturation with IDXW=4: 17 beats of value 1 with the last beat 0 -> Count=15, Sat=1, Min=0 at idx 15, Max=1 at idx 0.
REQ-036 Reset mid-frame: reset_n pulsed low after 2 beats -> all outputs 0 and no OutValid; a new frame of beats 9 (last) -> Min=Max=9, Count=1.

Source files
------------

// File: rtl/minmax_if.sv
// minmax_if: beat-in / result-out handshake bundle for minmax_tracker.
interface minmax_if #(
    parameter int WIDTH = 64,
    parameter int IDXW  = 16
) ();
    logic             Start;
    logic             Signed;
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] InData;
    logic             InLast;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Min;
    logic [WIDTH-1:0] Max;
    logic [IDXW-1:0]  MinIdx;
    logic [IDXW-1:0]  MaxIdx;
    logic [IDXW-1:0]  Count;
    logic             Sat;

    modport master (
        output Start, Signed, InValid, InData, InLast, OutReady,
        input  InReady, OutValid, Min, Max, MinIdx, MaxIdx, Count, Sat
    );

    modport slave (
        input  Start, Signed, InValid, InData, InLast, OutReady,
        output InReady, OutValid, Min, Max, MinIdx, MaxIdx, Count, Sat
    );
endinterface

// File: rtl/minmax_tracker.sv
// minmax_tracker: per-frame min/max with first-occurrence indices, one beat per clock.
module minmax_tracker #(
    parameter int WIDTH = 64,
    parameter int IDXW  = 16
) (
    input logic     clk,
    input logic     reset_n,
    minmax_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t           state_q, state_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d;
    logic [IDXW-1:0]  min_idx_q, min_idx_d, max_idx_q, max_idx_d, count_q, count_d;
    logic             sat_q, sat_d;
    logic             beat, first, full, lt_min, gt_max;
    logic [WIDTH-1:0] key_in, key_min, key_max;

    always_comb begin
        beat      = state_q == ACCUM && bus.InValid;
        first     = count_q == '0;
        full      = &count_q;
        // Flipping the MSB maps two's complement order onto unsigned order
        key_in    = {bus.InData[WIDTH-1] ^ mode_q, bus.InData[WIDTH-2:0]};
        key_min   = {min_q[WIDTH-1] ^ mode_q, min_q[WIDTH-2:0]};
        key_max   = {max_q[WIDTH-1] ^ mode_q, max_q[WIDTH-2:0]};
        lt_min    = key_in < key_min;
        gt_max    = key_in > key_max;
        state_d   = state_q;
        mode_d    = mode_q;
        min_d     = min_q;
        max_d     = max_q;
        min_idx_d = min_idx_q;
        max_idx_d = max_idx_q;
        count_d   = count_q;
        sat_d     = sat_q;
        case (state_q)
            IDLE: if (bus.Start) begin
                state_d   = ACCUM;
                mode_d    = bus.Signed;
                count_d   = '0;
                sat_d     = 1'b0;
                min_idx_d = '0;
                max_idx_d = '0;
            end
            ACCUM: if (beat) begin
                if (first || lt_min) begin
                    min_d     = bus.InData;
                    min_idx_d = count_q;
                end
                if (first || gt_max) begin
                    max_d     = bus.InData;
                    max_idx_d = count_q;
                end
                count_d = full ? count_q : count_q + 1'b1;
                sat_d   = sat_q | full;
                state_d = bus.InLast ? DONE : ACCUM;
            end
            DONE: state_d = bus.OutReady ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            min_q     <= '0;
            max_q     <= '0;
            min_idx_q <= '0;
            max_idx_q <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            min_q     <= min_d;
            max_q     <= max_d;
            min_idx_q <= min_idx_d;
            max_idx_q <= max_idx_d;
            count_q   <= count_d;
            sat_q     <= sat_d;
        end
    end

    assign bus.InReady  = state_q == ACCUM;
    assign bus.OutValid = state_q == DONE;
    assign bus.Min      = min_q;
    assign bus.Max      = max_q;
    assign bus.MinIdx   = min_idx_q;
    assign bus.MaxIdx   = max_idx_q;
    assign bus.Count    = count_q;
    assign bus.Sat      = sat_q;
endmodule
